// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths for the fetch stage and the
// sequential PC increment (one 32-bit instruction = 4 bytes).
package cpu_pkg;

  localparam int PC_W    = 64;
  localparam int COND_W  = 19;
  localparam int BR_W    = 26;
  localparam int PC_INCR = 4;

endpackage : cpu_pkg

// File: rtl/adder64_bit.sv
// Ripple-carry adder/subtractor built from a chain of full adders.
// sub=1 computes a - b by inverting b and injecting a carry-in of 1.
module adder64_bit import cpu_pkg::*; #(
  parameter int W = PC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         overflow,
  output logic         carry
);

  logic [W:0]   c;
  logic [W-1:0] b_eff;

  assign b_eff = b ^ {W{sub}};
  assign c[0]  = sub;

  // One full adder per bit position, carry rippling upward.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_fa
      assign sum[gi]   = a[gi] ^ b_eff[gi] ^ c[gi];
      assign c[gi + 1] = (a[gi] & b_eff[gi]) | (c[gi] & (a[gi] ^ b_eff[gi]));
    end
  endgenerate

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign carry    = c[W];
  assign overflow = c[W] ^ c[W-1];

endmodule : adder64_bit

// File: rtl/adder_4_pc.sv
// Sequential-address incrementer: pc + 4, wrapping modulo 2^W.
module adder_4_pc import cpu_pkg::*; #(
  parameter int W = PC_W
) (
  input  logic [W-1:0] pc,
  output logic [W-1:0] sum
);

  // Carry out of the top bit is discarded, so the top word wraps to 0.
  always_comb begin
    sum = pc + W'(PC_INCR);
  end

endmodule : adder_4_pc

// File: rtl/mux64x2_1.sv
// Generic 2:1 multiplexer: sel=0 passes in0, sel=1 passes in1.
module mux64x2_1 import cpu_pkg::*; #(
  parameter int W = PC_W
) (
  input  logic         sel,
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  output logic [W-1:0] out
);

  // Pure selection, no storage.
  always_comb begin
    out = in0;
    if (sel) begin
      out = in1;
    end
  end

endmodule : mux64x2_1

// File: rtl/program_counter.sv
// Fetch-stage program counter. Holds the PC and selects the next PC from
// PC+4, a PC-relative branch target, or a register target (BR).
// Priority: branch_reg > br_taken > sequential.
module program_counter #(
  parameter int COND_W = cpu_pkg::COND_W,
  parameter int BR_W   = cpu_pkg::BR_W,
  parameter int PC_W   = cpu_pkg::PC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic [COND_W-1:0] cond_addr19,
  input  logic [BR_W-1:0]   br_addr26,
  input  logic              uncond_br,
  input  logic              br_taken,
  input  logic              branch_reg,
  input  logic [PC_W-1:0]   rd,
  output logic [PC_W-1:0]   curr_pc,
  output logic [PC_W-1:0]   next_pc,
  output logic [PC_W-1:0]   pc_plus4
);

  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] cond_sext;
  logic [PC_W-1:0] br_sext;
  logic [PC_W-1:0] cond_byte_off;
  logic [PC_W-1:0] br_byte_off;
  logic [PC_W-1:0] byte_off;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] rel_or_seq;
  logic [1:0]      unused_add_flags;

  // Word offsets become signed byte offsets: sign-extend, then shift by 2.
  // The two bits shifted off the top are simply dropped.
  assign cond_sext     = {{(PC_W-COND_W){cond_addr19[COND_W-1]}}, cond_addr19};
  assign br_sext       = {{(PC_W-BR_W){br_addr26[BR_W-1]}}, br_addr26};
  assign cond_byte_off = {cond_sext[PC_W-3:0], 2'b00};
  assign br_byte_off   = {br_sext[PC_W-3:0], 2'b00};

  // CB-format vs. B-format offset.
  mux64x2_1 #(.W(PC_W)) u_off_mux (
    .sel (uncond_br),
    .in0 (cond_byte_off),
    .in1 (br_byte_off),
    .out (byte_off)
  );

  // Two's-complement add handles backward branches; flags are irrelevant.
  adder64_bit #(.W(PC_W)) u_branch_add (
    .a        (pc_reg),
    .b        (byte_off),
    .sub      (1'b0),
    .sum      (branch_target),
    .overflow (unused_add_flags[0]),
    .carry    (unused_add_flags[1])
  );

  adder_4_pc #(.W(PC_W)) u_plus4 (
    .pc  (pc_reg),
    .sum (pc_plus4)
  );

  // Taken PC-relative branch vs. fall-through.
  mux64x2_1 #(.W(PC_W)) u_taken_mux (
    .sel (br_taken),
    .in0 (pc_plus4),
    .in1 (branch_target),
    .out (rel_or_seq)
  );

  // BR overrides everything; rd passes through with no alignment fixup.
  mux64x2_1 #(.W(PC_W)) u_reg_mux (
    .sel (branch_reg),
    .in0 (rel_or_seq),
    .in1 (rd),
    .out (next_pc)
  );

  // PC register: async clear, load on pc_write, otherwise hold (stall).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= '0;
    end else if (pc_write) begin
      pc_reg <= next_pc;
    end
  end

  assign curr_pc = pc_reg;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a stimulus process drives the
// inputs and queues expected outputs from an arithmetic reference model;
// a monitor process pops and compares whenever a sample is announced.
module tb_program_counter;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic [18:0] cond_addr19;
  logic [25:0] br_addr26;
  logic        uncond_br;
  logic        br_taken;
  logic        branch_reg;
  logic [63:0] rd;
  logic [63:0] curr_pc;
  logic [63:0] next_pc;
  logic [63:0] pc_plus4;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [63:0] curr;
    logic [63:0] nxt;
    logic [63:0] p4;
  } exp_t;

  exp_t        exp_q[$];
  event        ev_sample;
  logic [63:0] model_pc;

  program_counter dut (
    .clk         (clk),
    .reset       (reset),
    .pc_write    (pc_write),
    .cond_addr19 (cond_addr19),
    .br_addr26   (br_addr26),
    .uncond_br   (uncond_br),
    .br_taken    (br_taken),
    .branch_reg  (branch_reg),
    .rd          (rd),
    .curr_pc     (curr_pc),
    .next_pc     (next_pc),
    .pc_plus4    (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: next PC from the selection rules, plain 64-bit arithmetic.
  function automatic logic [63:0] model_next(
    input logic [63:0] pc, input bit breg, input bit taken, input bit unc,
    input logic [63:0] rdv, input logic [18:0] c, input logic [25:0] b);
    longint off;
    if (breg) return rdv;
    if (!taken) return pc + 64'd4;
    if (unc) off = longint'(signed'(b));
    else     off = longint'(signed'(c));
    return pc + 64'(off * 4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(ev_sample);
      if (exp_q.size() == 0) begin
        check("queue_underflow", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, ".curr_pc"}, curr_pc, e.curr);
        check({e.tag, ".next_pc"}, next_pc, e.nxt);
        check({e.tag, ".pc_plus4"}, pc_plus4, e.p4);
        $display("txn %-12s curr=%h next=%h plus4=%h", e.tag, curr_pc, next_pc, pc_plus4);
      end
    end
  end

  // One cycle: drive at the falling edge, sample 1 time unit later,
  // then advance the model across the rising edge.
  task automatic drive(input bit rst, input bit pw, input bit breg, input bit taken,
                       input bit unc, input logic [63:0] rdv, input logic [18:0] c,
                       input logic [25:0] b, input string tag);
    exp_t e;
    reset       = rst;
    pc_write    = pw;
    branch_reg  = breg;
    br_taken    = taken;
    uncond_br   = unc;
    rd          = rdv;
    cond_addr19 = c;
    br_addr26   = b;
    #1;
    if (!rst) model_pc = 64'd0;
    e.tag  = tag;
    e.curr = model_pc;
    e.nxt  = model_next(model_pc, breg, taken, unc, rdv, c, b);
    e.p4   = model_pc + 64'd4;
    exp_q.push_back(e);
    -> ev_sample;
    @(posedge clk);
    if (rst && pw) model_pc = e.nxt;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; pc_write = 1'b0; branch_reg = 1'b0; br_taken = 1'b0;
    uncond_br = 1'b0; rd = '0; cond_addr19 = '0; br_addr26 = '0;
    model_pc = 64'd0;
    @(negedge clk);

    // Reset held, then three sequential steps.
    drive(0, 1, 0, 0, 0, 0, 0, 0, "rst_hold0");
    drive(0, 1, 0, 0, 0, 0, 0, 0, "rst_hold1");
    drive(1, 1, 0, 0, 0, 0, 0, 0, "seq0");
    drive(1, 1, 0, 0, 0, 0, 0, 0, "seq1");
    drive(1, 1, 0, 0, 0, 0, 0, 0, "seq2");
    // Register load then sequential (curr should read 0x0C first).
    drive(1, 1, 1, 0, 0, 64'hFF, 0, 0, "rd_load");
    drive(1, 1, 0, 0, 0, 0, 0, 0, "seq_after_rd");
    // Conditional forward from 0x0F.
    drive(1, 1, 1, 0, 0, 64'h0F, 0, 0, "load_0f");
    drive(1, 0, 0, 1, 0, 0, 19'd30, 0, "cond_fwd");
    // Unconditional forward from 0 (async reset mid-operation first).
    drive(0, 1, 0, 1, 0, 0, 19'd30, 0, "async_rst");
    drive(1, 0, 0, 1, 1, 0, 0, 26'd2, "uncond_fwd");
    // Negative offsets from 200.
    drive(1, 1, 1, 0, 0, 64'd200, 0, 0, "load_200");
    drive(1, 0, 0, 1, 0, 0, 19'h7FFFF, 0, "cond_neg");
    drive(1, 0, 0, 1, 1, 0, 0, 26'h3FFFFFB, "uncond_neg");
    // Register priority over br_taken, then stall.
    drive(1, 1, 1, 1, 1, 64'd69, 19'd5, 26'd7, "reg_prio");
    drive(1, 0, 0, 0, 0, 0, 0, 0, "stall0");
    drive(1, 0, 0, 1, 0, 0, 19'd9, 0, "stall1");
    drive(1, 1, 0, 0, 0, 0, 0, 0, "after_stall");
    // Top-of-address-space wrap.
    drive(1, 1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, "load_top");
    drive(1, 1, 0, 0, 0, 0, 0, 0, "wrap");
    drive(1, 1, 1, 0, 0, 64'h1235, 0, 0, "rd_unaligned");
    drive(1, 1, 0, 0, 0, 0, 0, 0, "post_unaligned");

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 4),
            1'($urandom), {$urandom, $urandom}, 19'($urandom), 26'($urandom),
            $sformatf("rand%0d", i));
    end

    #20;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_program_counter
